// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// Latency: none, signal bundle only.
// Backpressure: none; start is a request that the slave accepts only when idle.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell plus a borrow flop.
// Latency: WIDTH+1 edges from the accepting edge to the done pulse.
// Backpressure: start is accepted only in IDLE; requests in RUN/DONE are dropped.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             bin;
    logic             a_msb;
    logic             b_msb;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             ovf_q;

    logic             a0;
    logic             b0;
    logic             d;
    logic             bout;
    logic [WIDTH:0]   res_ext;
    logic [WIDTH-1:0] res_nxt;
    logic             last_bit;

    // Full-subtractor cell on the current operand LSBs, plus the shifted result.
    always_comb begin
        a0       = a_sr[0];
        b0       = b_sr[0];
        d        = a0 ^ b0 ^ bin;
        bout     = (~a0 & b0) | (~(a0 ^ b0) & bin);
        // Concatenate-then-drop-LSB keeps the shift legal even for WIDTH=1.
        res_ext  = {d, res};
        res_nxt  = res_ext[WIDTH:1];
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    // Control FSM, operand/result shifters and the held output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res      <= '0;
            cnt      <= '0;
            bin      <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr  <= bus.a;
                        b_sr  <= bus.b;
                        a_msb <= bus.a[WIDTH-1];
                        b_msb <= bus.b[WIDTH-1];
                        bin   <= 1'b0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    res  <= res_nxt;
                    bin  <= bout;
                    cnt  <= cnt + CW'(1);
                    if (last_bit) begin
                        diff_q   <= res_nxt;
                        borrow_q <= bout;
                        // Signed overflow: operand signs differ and the result sign flips away from a.
                        ovf_q    <= (a_msb ^ b_msb) & (d ^ a_msb);
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = (state == RUN);
    assign bus.done   = (state == DONE);
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1.
// Latency: checks done at WIDTH+1 edges after acceptance and 10-edge spacing back-to-back.
// Backpressure: exercises start held high, start during RUN, and reset mid-operation.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) bus8();
    serial_subtractor_if #(.WIDTH(1)) bus1();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       br;
        logic       ov;
    } vec_t;

    vec_t tbl [7];
    vec_t tbl1 [4];

    logic [7:0] ha [130];
    logic [7:0] hb [130];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Plain integer arithmetic reference for an 8-bit subtract.
    function automatic void ref8(input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] d, output logic br, output logic ov);
        int ua, ub, sa, sb, sd;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        sd = sa - sb;
        d  = 8'(ua - ub);
        br = (ua < ub);
        ov = (sd > 127) || (sd < -128);
    endfunction

    // Launch one 8-bit op, scramble operands after acceptance, wait for done.
    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] d, output logic br, output logic ov,
                       output int nbusy, output bit got, output bit overlap);
        got = 1'b0; nbusy = 0; overlap = 1'b0; d = '0; br = 1'b0; ov = 1'b0;
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = a; bus8.b = b;
        @(negedge clk);
        bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom);
        for (int i = 0; i < 40; i++) begin
            if (bus8.busy && bus8.done) overlap = 1'b1;
            if (bus8.done) begin
                got = 1'b1; d = bus8.diff; br = bus8.borrow; ov = bus8.ovf;
                break;
            end
            if (bus8.busy) nbusy++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] d, ed;
        logic       br, ov, ebr, eov;
        int         nbusy, ndone, last;
        bit         got, overlap;

        tbl[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0};
        tbl[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        tbl[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        tbl[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        tbl[4] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{8'h00, 8'h80, 8'h80, 1'b1, 1'b1};
        tbl[6] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};

        tbl1[0] = '{8'h0, 8'h0, 8'h0, 1'b0, 1'b0};
        tbl1[1] = '{8'h0, 8'h1, 8'h1, 1'b1, 1'b1};
        tbl1[2] = '{8'h1, 8'h0, 8'h1, 1'b0, 1'b0};
        tbl1[3] = '{8'h1, 8'h1, 8'h0, 1'b0, 1'b0};

        rst = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
        repeat (2) @(negedge clk);
        check("reset busy",   32'(bus8.busy),   32'(0));
        check("reset done",   32'(bus8.done),   32'(0));
        check("reset diff",   32'(bus8.diff),   32'(0));
        check("reset borrow", 32'(bus8.borrow), 32'(0));
        check("reset ovf",    32'(bus8.ovf),    32'(0));
        check("reset busy w1", 32'(bus1.busy),  32'(0));
        rst = 1'b0;

        // Directed table, WIDTH=8.
        for (int i = 0; i < 7; i++) begin
            op8(tbl[i].a, tbl[i].b, d, br, ov, nbusy, got, overlap);
            check($sformatf("tbl%0d done seen", i), 32'(got), 32'(1));
            check($sformatf("tbl%0d diff", i),   32'(d),  32'(tbl[i].d));
            check($sformatf("tbl%0d borrow", i), 32'(br), 32'(tbl[i].br));
            check($sformatf("tbl%0d ovf", i),    32'(ov), 32'(tbl[i].ov));
            check($sformatf("tbl%0d busy cycles", i), 32'(nbusy), 32'(8));
            check($sformatf("tbl%0d busy&done", i), 32'(overlap), 32'(0));
            @(negedge clk);
            check($sformatf("tbl%0d done width", i), 32'(bus8.done), 32'(0));
            check($sformatf("tbl%0d idle busy", i),  32'(bus8.busy), 32'(0));
        end

        // start re-asserted during RUN with new operands: ignored, not queued.
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h01;
        @(negedge clk);
        bus8.a = 8'hFF; bus8.b = 8'hFF;
        ndone = 0; d = '0;
        for (int i = 0; i < 9; i++) begin
            if (bus8.done) begin ndone++; d = bus8.diff; end
            if (i < 8) @(negedge clk);
        end
        check("restart done count", 32'(ndone), 32'(1));
        check("restart diff", 32'(d), 32'(8'h0F));
        check("restart idle busy", 32'(bus8.busy), 32'(0));
        bus8.start = 1'b0;
        repeat (2) @(negedge clk);
        check("restart no second op", 32'(bus8.busy), 32'(0));
        check("restart no second done", 32'(bus8.done), 32'(0));

        // Reset after 4 RUN edges abandons the op and clears outputs.
        bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy",   32'(bus8.busy),   32'(0));
        check("midrst done",   32'(bus8.done),   32'(0));
        check("midrst diff",   32'(bus8.diff),   32'(0));
        check("midrst borrow", 32'(bus8.borrow), 32'(0));
        check("midrst ovf",    32'(bus8.ovf),    32'(0));
        op8(8'h03, 8'h05, d, br, ov, nbusy, got, overlap);
        check("postrst done seen", 32'(got), 32'(1));
        check("postrst diff",   32'(d),  32'(8'hFE));
        check("postrst borrow", 32'(br), 32'(1));
        @(negedge clk);

        // WIDTH=1 truth table; done one edge after acceptance.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus1.start = 1'b1; bus1.a = 1'(tbl1[i].a); bus1.b = 1'(tbl1[i].b);
            @(negedge clk);
            bus1.start = 1'b0; bus1.a = ~bus1.a; bus1.b = ~bus1.b;
            check($sformatf("w1 case%0d busy", i), 32'(bus1.busy), 32'(1));
            check($sformatf("w1 case%0d early done", i), 32'(bus1.done), 32'(0));
            @(negedge clk);
            check($sformatf("w1 case%0d done", i),   32'(bus1.done),   32'(1));
            check($sformatf("w1 case%0d diff", i),   32'(bus1.diff),   32'(tbl1[i].d[0]));
            check($sformatf("w1 case%0d borrow", i), 32'(bus1.borrow), 32'(tbl1[i].br));
            check($sformatf("w1 case%0d ovf", i),    32'(bus1.ovf),    32'(tbl1[i].ov));
            @(negedge clk);
            check($sformatf("w1 case%0d done width", i), 32'(bus1.done), 32'(0));
        end

        // Random back-to-back with start held high: operands driven at negedge n
        // are accepted on the next edge, so their done shows at negedge n+9.
        @(negedge clk);
        bus8.start = 1'b1;
        ndone = 0; last = -1;
        for (int n = 0; n < 130; n++) begin
            if (bus8.busy && bus8.done) check("rand busy&done", 32'(1), 32'(0));
            if (bus8.done) begin
                if (n < 9) begin
                    check("rand early done index", 32'(n), 32'(9));
                end else begin
                    ref8(ha[n-9], hb[n-9], ed, ebr, eov);
                    check($sformatf("rand@%0d diff", n),   32'(bus8.diff),   32'(ed));
                    check($sformatf("rand@%0d borrow", n), 32'(bus8.borrow), 32'(ebr));
                    check($sformatf("rand@%0d ovf", n),    32'(bus8.ovf),    32'(eov));
                end
                if (last >= 0) check($sformatf("rand@%0d spacing", n), 32'(n - last), 32'(10));
                last = n;
                ndone++;
            end
            ha[n] = 8'($urandom);
            hb[n] = 8'($urandom);
            bus8.a = ha[n];
            bus8.b = hb[n];
            @(negedge clk);
        end
        bus8.start = 1'b0;
        check("rand done count", 32'(ndone), 32'(13));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
